// File: rtl/uart_ascii_sender.sv
// rtl/uart_ascii_sender.sv - UART transmitter for a 9-character ASCII reading, MSD first, optional CR LF.
module uart_ascii_sender #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int SEND_CRLF    = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Send,
  input  logic [71:0] Data_in,
  output logic        Busy,
  output logic        Done,
  output logic        Tx
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0] LAST_IDX = (SEND_CRLF != 0) ? 4'd10 : 4'd8;

  // The "next character" decision is folded into the final stop-bit edge,
  // so it occupies no bit time and needs no state of its own.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [3:0]        idx_q, idx_d;
  logic [71:0]       shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              done_q, done_d;
  logic [7:0]        cur_char;
  logic [2:0]        bit_nx;
  logic              baud_last;

  assign baud_last = (baud_q == BAUD_LAST);
  assign bit_nx    = bit_q + 3'd1;

  always_comb begin
    cur_char = shift_q[71:64];
    if (idx_q == 4'd9) cur_char = 8'h0D;
    else if (idx_q == 4'd10) cur_char = 8'h0A;
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    tx_d    = 1'b1;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (Send) begin
          state_d = START;
          baud_d  = '0;
          bit_d   = 3'd0;
          idx_d   = 4'd0;
          shift_d = Data_in;
          tx_d    = 1'b0;
        end
      end
      START: begin
        tx_d   = 1'b0;
        baud_d = baud_q + 1'b1;
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          state_d = DATA;
          tx_d    = cur_char[0];
        end
      end
      DATA: begin
        tx_d   = cur_char[bit_q];
        baud_d = baud_q + 1'b1;
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_nx;
            tx_d  = cur_char[bit_nx];
          end
        end
      end
      STOP: begin
        tx_d   = 1'b1;
        baud_d = baud_q + 1'b1;
        if (baud_last) begin
          baud_d = '0;
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = START;
            idx_d   = idx_q + 4'd1;
            shift_d = {shift_q[63:0], 8'h00};
            tx_d    = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      idx_q   <= 4'd0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  assign Busy = (state_q != IDLE);
  assign Done = done_q;
  assign Tx   = tx_q;

endmodule

// File: tb/tb_uart_ascii_sender.sv
// tb/tb_uart_ascii_sender.sv - Directed bench for uart_ascii_sender with CRLF and no-CRLF instances.
module tb_uart_ascii_sender;

  localparam int CPB = 4;

  localparam logic [71:0] D_BASIC = 72'h313233343536373839;
  localparam logic [71:0] D_ZERO  = 72'h303030303030303030;
  localparam logic [71:0] D_NINE  = 72'h393939393939393939;
  localparam logic [71:0] D_42    = 72'h303030303030303432;

  logic        clk = 1'b0;
  logic        rst;
  logic        send1, send0;
  logic [71:0] data_in;
  logic        busy1, done1, tx1;
  logic        busy0, done0, tx0;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  uart_ascii_sender #(.CLKS_PER_BIT(CPB), .SEND_CRLF(1)) dut1 (
    .CLK(clk), .RST(rst), .Send(send1), .Data_in(data_in),
    .Busy(busy1), .Done(done1), .Tx(tx1)
  );

  uart_ascii_sender #(.CLKS_PER_BIT(CPB), .SEND_CRLF(0)) dut0 (
    .CLK(clk), .RST(rst), .Send(send0), .Data_in(data_in),
    .Busy(busy0), .Done(done0), .Tx(tx0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic [7:0] exp_char(input logic [71:0] d, input int c);
    if (c < 9) return d[71 - 8*c -: 8];
    else if (c == 9) return 8'h0D;
    else return 8'h0A;
  endfunction

  // Pulse Send on one instance; returns at the negedge right after the accepting edge.
  task automatic pulse_send(input bit crlf, input logic [71:0] d);
    data_in = d;
    if (crlf) send1 = 1'b1; else send0 = 1'b1;
    step();
    send1 = 1'b0;
    send0 = 1'b0;
  endtask

  // Checks the whole waveform cycle by cycle, decodes mid-bit, and returns in the Done cycle.
  task automatic check_line(input string tag, input logic [71:0] d, input bit crlf, input int poke);
    int n, total, werr, c, bpos;
    logic tx, busy, done, expbit;
    logic [7:0] ch;
    logic [9:0] rxw [0:10];
    n = crlf ? 11 : 9;
    total = n * 10 * CPB;
    werr = 0;
    for (int i = 0; i < 11; i++) rxw[i] = '0;
    for (int m = 0; m < total; m++) begin
      tx   = crlf ? tx1 : tx0;
      busy = crlf ? busy1 : busy0;
      done = crlf ? done1 : done0;
      c    = m / (10 * CPB);
      bpos = (m % (10 * CPB)) / CPB;
      ch   = exp_char(d, c);
      if (bpos == 0) expbit = 1'b0;
      else if (bpos == 9) expbit = 1'b1;
      else expbit = ch[bpos-1];
      if (tx !== expbit || busy !== 1'b1 || done !== 1'b0) werr++;
      if ((m % CPB) == CPB / 2) rxw[c][bpos] = tx;
      if (m == poke) begin
        data_in = D_NINE;
        if (crlf) send1 = 1'b1; else send0 = 1'b1;
      end
      if (m == poke + 1) begin
        send1 = 1'b0;
        send0 = 1'b0;
      end
      step();
    end
    chk({tag, "_wave"}, werr, 0);
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_char%0d", tag, i), {22'd0, rxw[i]}, {22'd0, 1'b1, exp_char(d, i), 1'b0});
    chk({tag, "_done"}, crlf ? done1 : done0, 1);
    chk({tag, "_busy_end"}, crlf ? busy1 : busy0, 0);
    chk({tag, "_tx_end"}, crlf ? tx1 : tx0, 1);
  endtask

  initial begin
    int derr;
    rst = 1'b1;
    send1 = 1'b1;
    send0 = 1'b1;
    data_in = D_BASIC;

    // Reset held with Send high
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_tx", {tx1, tx0}, 2'b11);
      chk("rst_busy", {busy1, busy0}, 2'b00);
      chk("rst_done", {done1, done0}, 2'b00);
    end
    rst = 1'b0;
    send1 = 1'b0;
    send0 = 1'b0;
    step();
    chk("post_rst_busy", {busy1, busy0}, 2'b00);
    chk("post_rst_tx", {tx1, tx0}, 2'b11);

    // Basic line with CR LF: 440 cycles
    pulse_send(1'b1, D_BASIC);
    check_line("basic", D_BASIC, 1'b1, -1);
    step();
    chk("basic_done_once", done1, 0);

    // No CR LF, all zeros: 360 cycles
    pulse_send(1'b0, D_ZERO);
    check_line("zeros", D_ZERO, 1'b0, -1);
    step();
    chk("zeros_done_once", done0, 0);

    // Send during Busy with changed data is dropped
    pulse_send(1'b1, D_BASIC);
    check_line("busy_send", D_BASIC, 1'b1, 100);
    step();
    chk("busy_send_no_queue", {busy1, done1}, 2'b00);

    // Back-to-back lines: Send in the Done cycle
    pulse_send(1'b0, D_ZERO);
    check_line("b2b_first", D_ZERO, 1'b0, -1);
    pulse_send(1'b0, D_42);
    check_line("b2b_second", D_42, 1'b0, -1);
    step();
    chk("b2b_done_once", done0, 0);

    // Reset during character 4, data bit 3
    pulse_send(1'b1, D_BASIC);
    for (int m = 0; m < 177; m++) step();
    chk("pre_rst_busy", busy1, 1);
    rst = 1'b1;
    step();
    chk("midrst_tx", tx1, 1);
    chk("midrst_busy", busy1, 0);
    chk("midrst_done", done1, 0);
    rst = 1'b0;
    derr = 0;
    for (int m = 0; m < 400; m++) begin
      step();
      if (done1 !== 1'b0 || busy1 !== 1'b0 || tx1 !== 1'b1) derr++;
    end
    chk("midrst_quiet", derr, 0);
    pulse_send(1'b1, D_BASIC);
    check_line("after_rst", D_BASIC, 1'b1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
